pn_gen_multi: RTL and testbench

PN_GEN_MULTI -- requirements
Module: pn_gen_multi

---
 rtl/pn_pkg.sv | 51 +++++
 rtl/pn_lfsr_ch.sv | 121 ++++++++++++
 rtl/pn_gen_multi.sv | 95 +++++++++
 tb/tb_pn_gen_multi.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pn_pkg.sv
// Shared definitions for the multi-channel PN generator: order codes,
// LFSR tap table, channel FSM encoding and order-to-length lookup.
package pn_pkg;

    typedef enum logic [2:0] {
        ORD_PN3  = 3'd0,
        ORD_PN5  = 3'd1,
        ORD_PN7  = 3'd2,
        ORD_PN9  = 3'd3,
        ORD_PN11 = 3'd4,
        ORD_PN15 = 3'd5,
        ORD_PN23 = 3'd6,
        ORD_RSVD = 3'd7
    } pn_order_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } pn_fsm_e;

    // Register length n for an order code; reserved maps to the shortest
    // polynomial so a stray code can never index past the state.
    function automatic logic [4:0] pn_len(input logic [2:0] ord);
        case (pn_order_e'(ord))
            ORD_PN3:  pn_len = 5'd3;
            ORD_PN5:  pn_len = 5'd5;
            ORD_PN7:  pn_len = 5'd7;
            ORD_PN9:  pn_len = 5'd9;
            ORD_PN11: pn_len = 5'd11;
            ORD_PN15: pn_len = 5'd15;
            ORD_PN23: pn_len = 5'd23;
            default:  pn_len = 5'd3;
        endcase
    endfunction

    // Second feedback tap m for an order code (first tap is always n).
    function automatic logic [4:0] pn_tap(input logic [2:0] ord);
        case (pn_order_e'(ord))
            ORD_PN3:  pn_tap = 5'd2;
            ORD_PN5:  pn_tap = 5'd3;
            ORD_PN7:  pn_tap = 5'd6;
            ORD_PN9:  pn_tap = 5'd5;
            ORD_PN11: pn_tap = 5'd9;
            ORD_PN15: pn_tap = 5'd14;
            ORD_PN23: pn_tap = 5'd18;
            default:  pn_tap = 5'd2;
        endcase
    endfunction

endpackage

// File: rtl/pn_lfsr_ch.sv
// One PN channel: IDLE/LOAD/RUN control, phase accumulator that paces the
// chip rate, and a Fibonacci LFSR whose length is selected at LOAD time.
module pn_lfsr_ch
    import pn_pkg::*;
#(
    parameter int RATE_W    = 32,
    parameter int MAX_ORDER = 23
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_en,
    input  logic                 i_sync,
    input  logic [2:0]           i_order,
    input  logic [MAX_ORDER-1:0] i_seed,
    input  logic [RATE_W-1:0]    i_rate,
    output logic                 o_pn,
    output logic [MAX_ORDER-1:0] o_state,
    output logic                 o_valid
);

    localparam int IDX_W = (MAX_ORDER > 1) ? $clog2(MAX_ORDER) : 1;

    pn_fsm_e                r_fsm;
    logic                   r_en_d;
    logic [2:0]             r_order;
    logic [RATE_W-1:0]      r_rate;
    logic [RATE_W-1:0]      r_acc;
    logic [MAX_ORDER-1:0]   r_state;
    logic                   r_pn;
    logic                   r_valid;

    logic [RATE_W:0]        w_sum;
    logic [IDX_W-1:0]       w_run_hi;
    logic [IDX_W-1:0]       w_run_tp;
    logic                   w_fb;
    logic [MAX_ORDER-1:0]   w_next;
    logic [IDX_W-1:0]       w_ld_hi;
    logic [MAX_ORDER-1:0]   w_ld_mask;
    logic [MAX_ORDER-1:0]   w_ld_masked;
    logic [MAX_ORDER-1:0]   w_ld_state;

    // Low-len ones mask; the shift wraps to zero at len == MAX_ORDER so the
    // subtraction still yields all ones.
    function automatic logic [MAX_ORDER-1:0] len_mask(input logic [4:0] len);
        len_mask = (MAX_ORDER'(1) << len) - MAX_ORDER'(1);
    endfunction

    // Next-chip and seed-load datapath for the active and the shadow order.
    always_comb begin
        w_sum       = {1'b0, r_acc} + {1'b0, r_rate};
        w_run_hi    = IDX_W'(pn_len(r_order) - 5'd1);
        w_run_tp    = IDX_W'(pn_tap(r_order) - 5'd1);
        w_fb        = r_state[w_run_hi] ^ r_state[w_run_tp];
        w_next      = {r_state[MAX_ORDER-2:0], w_fb} & len_mask(pn_len(r_order));
        w_ld_hi     = IDX_W'(pn_len(i_order) - 5'd1);
        w_ld_mask   = len_mask(pn_len(i_order));
        w_ld_masked = i_seed & w_ld_mask;
        if (w_ld_masked == {MAX_ORDER{1'b0}}) begin
            w_ld_state = w_ld_mask;
        end else begin
            w_ld_state = w_ld_masked;
        end
    end

    // Channel FSM; r_en_d resets high so a channel needs a genuine ch_en
    // rise (or sync_rst) after reset before it produces chips.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fsm   <= ST_IDLE;
            r_en_d  <= 1'b1;
            r_order <= 3'd0;
            r_rate  <= {RATE_W{1'b0}};
            r_acc   <= {RATE_W{1'b0}};
            r_state <= {MAX_ORDER{1'b0}};
            r_pn    <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_en_d  <= i_en;
            r_valid <= 1'b0;
            if (!i_en) begin
                r_fsm <= ST_IDLE;
            end else begin
                case (r_fsm)
                    ST_IDLE: begin
                        if (!r_en_d || i_sync) begin
                            r_fsm <= ST_LOAD;
                        end else begin
                            r_fsm <= ST_IDLE;
                        end
                    end
                    ST_LOAD: begin
                        r_order <= i_order;
                        r_rate  <= i_rate;
                        r_acc   <= {RATE_W{1'b0}};
                        r_state <= w_ld_state;
                        r_pn    <= w_ld_state[w_ld_hi];
                        r_fsm   <= ST_RUN;
                    end
                    ST_RUN: begin
                        if (i_sync) begin
                            r_fsm <= ST_LOAD;
                        end else begin
                            r_acc <= w_sum[RATE_W-1:0];
                            if (w_sum[RATE_W]) begin
                                r_state <= w_next;
                                r_pn    <= w_next[w_run_hi];
                                r_valid <= 1'b1;
                            end
                        end
                    end
                    default: r_fsm <= ST_IDLE;
                endcase
            end
        end
    end

    assign o_pn    = r_pn;
    assign o_state = r_state;
    assign o_valid = r_valid;

endmodule

// File: rtl/pn_gen_multi.sv
// Multi-channel PN sequence generator: config handshake and decode, per-channel
// shadow registers and the sticky error flag, plus one pn_lfsr_ch per channel.
module pn_gen_multi
    import pn_pkg::*;
#(
    parameter int CH_NUM    = 2,
    parameter int RATE_W    = 32,
    parameter int MAX_ORDER = 23
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic                                       cfg_valid,
    output logic                                       cfg_ready,
    input  logic [((CH_NUM > 1) ? $clog2(CH_NUM) : 1)-1:0] cfg_ch,
    input  logic [2:0]                                 cfg_order,
    input  logic [MAX_ORDER-1:0]                       cfg_seed,
    input  logic [RATE_W-1:0]                          cfg_rate,
    input  logic [CH_NUM-1:0]                          ch_en,
    input  logic                                       sync_rst,
    output logic [CH_NUM-1:0]                          pn_out,
    output logic [CH_NUM*MAX_ORDER-1:0]                pn_state,
    output logic [CH_NUM-1:0]                          data_valid,
    output logic                                       cfg_err
);

    localparam int CH_W = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;

    logic                 r_cfg_ready;
    logic                 r_cfg_err;
    logic [2:0]           r_sh_order [CH_NUM];
    logic [MAX_ORDER-1:0] r_sh_seed  [CH_NUM];
    logic [RATE_W-1:0]    r_sh_rate  [CH_NUM];

    logic                 w_accept;
    logic                 w_legal;

    assign w_accept = cfg_valid && r_cfg_ready;
    assign w_legal  = (cfg_order != ORD_RSVD) &&
                      ({1'b0, cfg_ch} < (CH_W+1)'(CH_NUM));

    // Handshake: ready drops for exactly the clk after any accept; the
    // error flag latches on an accepted illegal write until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cfg_ready <= 1'b1;
            r_cfg_err   <= 1'b0;
        end else begin
            r_cfg_ready <= !w_accept;
            if (w_accept && !w_legal) begin
                r_cfg_err <= 1'b1;
            end
        end
    end

    // Shadow registers: only legal accepted writes touch the addressed channel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < CH_NUM; c++) begin
                r_sh_order[c] <= ORD_PN3;
                r_sh_seed[c]  <= MAX_ORDER'(1);
                r_sh_rate[c]  <= {RATE_W{1'b0}};
            end
        end else begin
            for (int c = 0; c < CH_NUM; c++) begin
                if (w_accept && w_legal && (cfg_ch == CH_W'(c))) begin
                    r_sh_order[c] <= cfg_order;
                    r_sh_seed[c]  <= cfg_seed;
                    r_sh_rate[c]  <= cfg_rate;
                end
            end
        end
    end

    assign cfg_ready = r_cfg_ready;
    assign cfg_err   = r_cfg_err;

    for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
        pn_lfsr_ch #(
            .RATE_W    (RATE_W),
            .MAX_ORDER (MAX_ORDER)
        ) u_ch (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_en    (ch_en[g]),
            .i_sync  (sync_rst),
            .i_order (r_sh_order[g]),
            .i_seed  (r_sh_seed[g]),
            .i_rate  (r_sh_rate[g]),
            .o_pn    (pn_out[g]),
            .o_state (pn_state[g*MAX_ORDER +: MAX_ORDER]),
            .o_valid (data_valid[g])
        );
    end

endmodule

// File: tb/tb_pn_gen_multi.sv
// Self-checking bench for pn_gen_multi: directed scenarios plus randomized
// traffic, all compared every clk against a behavioural channel model.
module tb_pn_gen_multi;

    localparam int CH = 3;
    localparam int RW = 32;
    localparam int MO = 23;
    localparam int LEN_T [8] = '{3, 5, 7, 9, 11, 15, 23, 3};
    localparam int TAP_T [8] = '{2, 3, 6, 5, 9, 14, 18, 2};
    localparam int PAT   [7] = '{0, 0, 1, 0, 1, 1, 1};
    localparam longint WRAP = 64'h1_0000_0000;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            cfg_valid;
    logic            cfg_ready;
    logic [1:0]      cfg_ch;
    logic [2:0]      cfg_order;
    logic [MO-1:0]   cfg_seed;
    logic [RW-1:0]   cfg_rate;
    logic [CH-1:0]   ch_en;
    logic            sync_rst;
    logic [CH-1:0]   pn_out;
    logic [CH*MO-1:0] pn_state;
    logic [CH-1:0]   data_valid;
    logic            cfg_err;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model state
    int     sh_ord [CH];
    int     sh_seed[CH];
    longint sh_rate[CH];
    bit     m_load [CH];
    bit     m_run  [CH];
    bit     m_prev [CH];
    bit     m_dv   [CH];
    longint m_acc  [CH];
    longint m_rate [CH];
    int     m_len  [CH];
    int     m_tap  [CH];
    int     m_st   [CH];
    bit     m_ready;
    bit     m_err;

    always #5 clk = ~clk;

    pn_gen_multi #(.CH_NUM(CH), .RATE_W(RW), .MAX_ORDER(MO)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_ch(cfg_ch), .cfg_order(cfg_order), .cfg_seed(cfg_seed),
        .cfg_rate(cfg_rate), .ch_en(ch_en), .sync_rst(sync_rst),
        .pn_out(pn_out), .pn_state(pn_state), .data_valid(data_valid),
        .cfg_err(cfg_err)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int seed_fix(input int seed, input int n);
        int mask = (1 << n) - 1;
        int v = seed & mask;
        return (v == 0) ? mask : v;
    endfunction

    function automatic int lfsr_step(input int s, input int n, input int m);
        int fb = ((s >> (n - 1)) ^ (s >> (m - 1))) & 1;
        return ((s << 1) | fb) & ((1 << n) - 1);
    endfunction

    task automatic model_reset();
        for (int c = 0; c < CH; c++) begin
            sh_ord[c] = 0; sh_seed[c] = 1; sh_rate[c] = 0;
            m_load[c] = 0; m_run[c] = 0; m_prev[c] = 1; m_dv[c] = 0;
            m_acc[c] = 0; m_rate[c] = 0; m_len[c] = 3; m_tap[c] = 2; m_st[c] = 0;
        end
        m_ready = 1; m_err = 0;
    endtask

    // One rising edge of the reference: channels see the pre-edge shadow values.
    task automatic model_edge();
        for (int c = 0; c < CH; c++) begin
            m_dv[c] = 0;
            if (!ch_en[c]) begin
                m_load[c] = 0; m_run[c] = 0;
            end else if (m_load[c]) begin
                m_len[c]  = LEN_T[sh_ord[c]];
                m_tap[c]  = TAP_T[sh_ord[c]];
                m_rate[c] = sh_rate[c];
                m_acc[c]  = 0;
                m_st[c]   = seed_fix(sh_seed[c], m_len[c]);
                m_load[c] = 0; m_run[c] = 1;
            end else if (m_run[c]) begin
                if (sync_rst) begin
                    m_run[c] = 0; m_load[c] = 1;
                end else begin
                    m_acc[c] += m_rate[c];
                    if (m_acc[c] >= WRAP) begin
                        m_acc[c] -= WRAP;
                        m_st[c] = lfsr_step(m_st[c], m_len[c], m_tap[c]);
                        m_dv[c] = 1;
                    end
                end
            end else if (!m_prev[c] || sync_rst) begin
                m_load[c] = 1;
            end
            m_prev[c] = ch_en[c];
        end
        if (cfg_valid && m_ready) begin
            if (cfg_order != 3'd7 && int'(cfg_ch) < CH) begin
                sh_ord[cfg_ch]  = int'(cfg_order);
                sh_seed[cfg_ch] = int'(cfg_seed);
                sh_rate[cfg_ch] = longint'(cfg_rate);
            end else begin
                m_err = 1;
            end
            m_ready = 0;
        end else begin
            m_ready = 1;
        end
    endtask

    task automatic compare_all();
        logic [CH-1:0]    e_pn;
        logic [CH-1:0]    e_dv;
        logic [CH*MO-1:0] e_st;
        for (int c = 0; c < CH; c++) begin
            e_pn[c] = 1'((m_st[c] >> (m_len[c] - 1)) & 1);
            e_dv[c] = m_dv[c];
            e_st[c*MO +: MO] = MO'(m_st[c]);
        end
        chk("pn_out", pn_out, e_pn);
        chk("data_valid", data_valid, e_dv);
        chk("pn_state", pn_state, e_st);
        chk("cfg_ready", cfg_ready, m_ready);
        chk("cfg_err", cfg_err, m_err);
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_edge();
        #1;
        compare_all();
    endtask

    task automatic cfg_write(input int ch, input int ord, input int seed,
                             input longint rate, input bit with_sync);
        cfg_valid = 1'b1;
        cfg_ch    = 2'(ch);
        cfg_order = 3'(ord);
        cfg_seed  = MO'(seed);
        cfg_rate  = RW'(rate);
        sync_rst  = with_sync;
        tick();
        cfg_valid = 1'b0;
        sync_rst  = 1'b0;
        tick();
    endtask

    function automatic longint pick_rate();
        case ($urandom_range(0, 4))
            0:       return 0;
            1:       return 64'hFFFF_FFFF;
            2:       return 64'h8000_0000;
            3:       return longint'($urandom_range(0, 255));
            default: return longint'($urandom);
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int got[$];
        int last;
        int steps;
        bit zero_seen;
        int k;

        rst_n = 1'b0; cfg_valid = 1'b0; cfg_ch = 2'd0; cfg_order = 3'd0;
        cfg_seed = {MO{1'b0}}; cfg_rate = {RW{1'b0}}; ch_en = 3'b000; sync_rst = 1'b0;
        model_reset();
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // PN3 at half rate on ch0; ch2 runs on its reset-default shadow values
        cfg_write(0, 0, 1, 64'h8000_0000, 1'b0);
        ch_en = 3'b101;
        last = -1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (data_valid[0]) begin
                if (last >= 0) chk("dv_spacing", i - last, 2);
                last = i;
                got.push_back(int'(pn_out[0]));
            end
        end
        chk("pn3_count", got.size(), 19);
        for (int i = 0; i < 14 && i < got.size(); i++) chk("pn3_seq", got[i], PAT[(i + 1) % 7]);
        chk("ch2_default", pn_state[2*MO +: MO], 23'd1);

        // PN9 with zero seed on ch1, stepping every clk
        cfg_write(1, 3, 0, 64'hFFFF_FFFF, 1'b0);
        ch_en[1] = 1'b1;
        tick();
        tick();
        chk("pn9_load", pn_state[MO +: MO], 23'h1FF);
        steps = 0; zero_seen = 1'b0;
        for (int i = 0; i < 600; i++) begin
            tick();
            if (data_valid[1]) steps++;
            if (pn_state[MO +: MO] == {MO{1'b0}}) zero_seen = 1'b1;
            if (data_valid[1] && pn_state[MO +: MO] == 23'h1FF) break;
        end
        chk("pn9_period", steps, 511);
        chk("pn9_nonzero", zero_seen, 1'b0);

        // Reconfigure ch1 while running; nothing changes until sync_rst
        cfg_write(1, 6, 23'h2A_5A5A, 64'h1234_5678, 1'b0);
        repeat (6) tick();
        sync_rst = 1'b1;
        tick();
        sync_rst = 1'b0;
        tick();
        chk("sync_ch0", pn_state[0 +: MO], 23'd1);
        chk("sync_ch1", pn_state[MO +: MO], 23'h2A_5A5A);
        repeat (4) tick();

        // Write coinciding with sync_rst: the reload uses the new values
        cfg_write(0, 2, 32'h55, 64'h4000_0000, 1'b1);
        chk("wr_sync_ch0", pn_state[0 +: MO], 23'h55);

        // Illegal writes: reserved order and out-of-range channel
        cfg_write(0, 7, 3, 64'hFFFF_FFFF, 1'b0);
        chk("err_rsvd", cfg_err, 1'b1);
        cfg_valid = 1'b1; cfg_ch = 2'd3; cfg_order = 3'd1; cfg_seed = 23'd9;
        tick();
        chk("ready_low", cfg_ready, 1'b0);
        tick();
        chk("ready_high", cfg_ready, 1'b1);
        cfg_valid = 1'b0;
        tick();
        sync_rst = 1'b1;
        tick();
        sync_rst = 1'b0;
        tick();
        chk("shadow_kept", pn_state[0 +: MO], 23'h55);
        repeat (5) tick();

        // Asynchronous reset mid-run
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_pn", pn_out, 3'b000);
        chk("arst_dv", data_valid, 3'b000);
        chk("arst_state", pn_state, {(CH*MO){1'b0}});
        chk("arst_err", cfg_err, 1'b0);
        chk("arst_ready", cfg_ready, 1'b1);
        model_reset();
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (10) tick();
        ch_en = 3'b000;
        tick();
        ch_en = 3'b111;
        repeat (8) tick();

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            cfg_valid = ($urandom_range(0, 7) == 0);
            cfg_ch    = 2'($urandom_range(0, 3));
            cfg_order = 3'($urandom_range(0, 7));
            cfg_seed  = ($urandom_range(0, 7) == 0) ? {MO{1'b0}} : MO'($urandom);
            cfg_rate  = RW'(pick_rate());
            sync_rst  = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 59) == 0) begin
                k = $urandom_range(0, CH - 1);
                ch_en[k] = ~ch_en[k];
            end
            tick();
        end
        cfg_valid = 1'b0;
        sync_rst  = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
